// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA plot engine and its helper blocks.
package vga_pkg;

  // Engine operating states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLOT  = 2'd1,
    ST_CLEAR = 2'd2
  } vga_state_e;

  // Default visible screen geometry.
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  // Field positions inside the 16-bit coordinate register.
  localparam int X_MSB = 15;
  localparam int X_LSB = 8;
  localparam int Y_MSB = 7;
  localparam int Y_LSB = 0;

  localparam int X_FIELD_W = X_MSB - X_LSB + 1;
  localparam int Y_FIELD_W = Y_MSB - Y_LSB + 1;

  // True when the full-width register coordinate lies on the visible screen.
  // Evaluated on the untruncated fields so that e.g. y=200 is rejected
  // rather than aliasing onto a visible row once narrowed.
  function automatic logic coord_in_range(
    input logic [X_FIELD_W-1:0] x,
    input logic [Y_FIELD_W-1:0] y,
    input int                   w,
    input int                   h
  );
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/vga_plot_engine_if.sv
// Control-path <-> plot engine bundle: request side plus adapter write port
// and status flags.
interface vga_plot_engine_if #(
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 7,
  parameter int COLOR_WIDTH = 3
);

  // Requests from the control path.
  logic                   plot;
  logic                   clear_n;
  logic [15:0]            color_value;
  logic [15:0]            coord_value;

  // Adapter write port.
  logic [X_WIDTH-1:0]     vga_x;
  logic [Y_WIDTH-1:0]     vga_y;
  logic [COLOR_WIDTH-1:0] vga_colour;
  logic                   vga_write;

  // Status back to the control path.
  logic                   busy;
  logic                   done;
  logic                   range_error;
  logic                   overrun;

  // Control path side.
  modport master (
    output plot, clear_n, color_value, coord_value,
    input  vga_x, vga_y, vga_colour, vga_write,
    input  busy, done, range_error, overrun
  );

  // Plot engine side.
  modport slave (
    input  plot, clear_n, color_value, coord_value,
    output vga_x, vga_y, vga_colour, vga_write,
    output busy, done, range_error, overrun
  );

endinterface

// File: rtl/vga_sweep_counter.sv
// Raster x/y counter: x is the inner loop, y the outer. Loaded to (0,0) by
// start, advanced by enable, wraps back to (0,0) after the last pixel.
// Kept generic so frame-copy logic can reuse the same sweep.
module vga_sweep_counter
  import vga_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int X_WIDTH  = 8,
  parameter int Y_WIDTH  = 7
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               enable,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y,
  output logic               last_pixel
);

  localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(SCREEN_W - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(SCREEN_H - 1);

  logic [X_WIDTH-1:0] x_q;
  logic [Y_WIDTH-1:0] y_q;

  // Position register: start wins over enable so a restart always begins
  // at the top-left corner.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else if (start) begin
      x_q <= '0;
      y_q <= '0;
    end else if (enable) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/vga_plot_engine.sv
// VGA plot engine: turns single-pixel plot strobes and full-screen clear
// requests into a one-pixel-per-cycle write stream for the VGA adapter,
// and reports busy/done so the control path can stall.
module vga_plot_engine
  import vga_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 7,
  parameter int COLOR_WIDTH = 3,
  parameter int CLEAR_COLOR = 0
) (
  input  logic              clock,
  input  logic              resetn,
  vga_plot_engine_if.slave  bus
);

  // FSM state and request bookkeeping.
  vga_state_e             state_q;
  logic                   clear_armed_q;
  logic [X_FIELD_W-1:0]   plot_x_q;
  logic [Y_FIELD_W-1:0]   plot_y_q;
  logic [COLOR_WIDTH-1:0] plot_colour_q;

  // Registered outputs.
  logic [X_WIDTH-1:0]     vga_x_q;
  logic [Y_WIDTH-1:0]     vga_y_q;
  logic [COLOR_WIDTH-1:0] vga_colour_q;
  logic                   vga_write_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   range_error_q;
  logic                   overrun_q;

  // Decoded request and sweep signals.
  logic [X_FIELD_W-1:0]   coord_x;
  logic [Y_FIELD_W-1:0]   coord_y;
  logic                   clear_req;
  logic                   plot_in_range;
  logic                   sweep_start;
  logic                   sweep_en;
  logic                   sweep_last;
  logic [X_WIDTH-1:0]     sweep_x;
  logic [Y_WIDTH-1:0]     sweep_y;
  logic                   unused_color_bits;

  assign coord_x = bus.coord_value[X_MSB:X_LSB];
  assign coord_y = bus.coord_value[Y_MSB:Y_LSB];

  // Only the low colour bits reach the adapter.
  assign unused_color_bits = &{1'b0, bus.color_value[15:COLOR_WIDTH]};

  // A clear is taken only from IDLE and only once per falling clear_n.
  assign clear_req     = (state_q == ST_IDLE) && !bus.clear_n && clear_armed_q;
  assign plot_in_range = coord_in_range(plot_x_q, plot_y_q, SCREEN_W, SCREEN_H);
  assign sweep_start   = clear_req;
  assign sweep_en      = (state_q == ST_CLEAR);

  vga_sweep_counter #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_WIDTH  (X_WIDTH),
    .Y_WIDTH  (Y_WIDTH)
  ) u_sweep (
    .clock      (clock),
    .resetn     (resetn),
    .start      (sweep_start),
    .enable     (sweep_en),
    .x          (sweep_x),
    .y          (sweep_y),
    .last_pixel (sweep_last)
  );

  // Engine FSM with all outputs registered. Each state's outputs describe
  // the pixel produced during that state, so they appear one edge later.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      clear_armed_q <= 1'b1;
      plot_x_q      <= '0;
      plot_y_q      <= '0;
      plot_colour_q <= '0;
      vga_x_q       <= '0;
      vga_y_q       <= '0;
      vga_colour_q  <= '0;
      vga_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      range_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      // Re-arm whenever clear_n is seen high; a held-low level clears once.
      if (bus.clear_n) begin
        clear_armed_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          vga_write_q   <= 1'b0;
          done_q        <= 1'b0;
          range_error_q <= 1'b0;
          busy_q        <= 1'b0;
          if (clear_req) begin
            state_q       <= ST_CLEAR;
            clear_armed_q <= 1'b0;
            busy_q        <= 1'b1;
            // A plot colliding with the clear is dropped.
            if (bus.plot) begin
              overrun_q <= 1'b1;
            end
          end else if (bus.plot) begin
            state_q       <= ST_PLOT;
            busy_q        <= 1'b1;
            plot_x_q      <= coord_x;
            plot_y_q      <= coord_y;
            plot_colour_q <= bus.color_value[COLOR_WIDTH-1:0];
          end
        end

        ST_PLOT: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          busy_q  <= 1'b1;
          if (plot_in_range) begin
            vga_write_q   <= 1'b1;
            range_error_q <= 1'b0;
            vga_x_q       <= X_WIDTH'(plot_x_q);
            vga_y_q       <= Y_WIDTH'(plot_y_q);
            vga_colour_q  <= plot_colour_q;
          end else begin
            // Off-screen: report instead of writing; the port keeps its
            // previous pixel.
            vga_write_q   <= 1'b0;
            range_error_q <= 1'b1;
          end
          if (bus.plot) begin
            overrun_q <= 1'b1;
          end
        end

        ST_CLEAR: begin
          vga_write_q   <= 1'b1;
          range_error_q <= 1'b0;
          busy_q        <= 1'b1;
          vga_x_q       <= sweep_x;
          vga_y_q       <= sweep_y;
          vga_colour_q  <= COLOR_WIDTH'(CLEAR_COLOR);
          done_q        <= sweep_last;
          if (sweep_last) begin
            state_q <= ST_IDLE;
          end
          if (bus.plot) begin
            overrun_q <= 1'b1;
          end
        end

        default: begin
          state_q       <= ST_IDLE;
          vga_write_q   <= 1'b0;
          done_q        <= 1'b0;
          range_error_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_colour_q;
  assign bus.vga_write   = vga_write_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.range_error = range_error_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_vga_plot_engine.sv
// Self-checking bench for vga_plot_engine: directed and random plots,
// raster clear, reset mid-clear, collisions and back-to-back strobes.
module tb_vga_plot_engine;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int NPIX = SW * SH;

  logic clk = 1'b0;
  logic resetn;
  int   tests_run = 0;
  int   tests_failed = 0;

  vga_plot_engine_if bus ();

  vga_plot_engine dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.plot = 1'b0;
    bus.clear_n = 1'b1;
    bus.color_value = '0;
    bus.coord_value = '0;
    repeat (3) tick();
    tests_run++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write, bus.busy, bus.done,
         bus.range_error, bus.overrun} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d w=%0b b=%0b d=%0b r=%0b o=%0b want all 0",
               bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write, bus.busy, bus.done,
               bus.range_error, bus.overrun);
    end
    resetn = 1'b1;
    tick();
    tests_run++;
    if ({bus.vga_write, bus.busy, bus.done, bus.range_error, bus.overrun} !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: got flags %b want 00000",
               {bus.vga_write, bus.busy, bus.done, bus.range_error, bus.overrun});
    end
    $display("[TB] reset sequence done");
  endtask

  task automatic test_plot();
    bus.coord_value = 16'h0A05;
    bus.color_value = 16'h0006;
    bus.plot = 1'b1;
    tick();
    bus.plot = 1'b0;
    tests_run++;
    if ({bus.vga_write, bus.done, bus.busy} !== 3'b001) begin
      tests_failed++;
      $display("FAIL plot_accept: got w/d/b=%b want 001", {bus.vga_write, bus.done, bus.busy});
    end
    tick();
    tests_run++;
    if ({bus.vga_write, bus.done, bus.range_error, bus.busy} !== 4'b1101) begin
      tests_failed++;
      $display("FAIL plot_flags: got w/d/r/b=%b want 1101",
               {bus.vga_write, bus.done, bus.range_error, bus.busy});
    end
    tests_run++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== {8'd10, 7'd5, 3'd6}) begin
      tests_failed++;
      $display("FAIL plot_pixel: got (%0d,%0d) c=%0d want (10,5) c=6",
               bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    tick();
    tests_run++;
    if ({bus.vga_write, bus.done, bus.range_error, bus.busy, bus.overrun} !== 5'd0) begin
      tests_failed++;
      $display("FAIL plot_idle: got w/d/r/b/o=%b want 00000",
               {bus.vga_write, bus.done, bus.range_error, bus.busy, bus.overrun});
    end
    $display("[TB] plot (10,5) colour 6");
  endtask

  task automatic test_range();
    bus.coord_value = 16'hA000;
    bus.color_value = 16'h0005;
    bus.plot = 1'b1;
    tick();
    bus.plot = 1'b0;
    tick();
    tests_run++;
    if ({bus.vga_write, bus.done, bus.range_error, bus.busy} !== 4'b0111) begin
      tests_failed++;
      $display("FAIL range_flags: got w/d/r/b=%b want 0111",
               {bus.vga_write, bus.done, bus.range_error, bus.busy});
    end
    tick();
    tests_run++;
    if ({bus.vga_write, bus.done, bus.range_error} !== 3'd0) begin
      tests_failed++;
      $display("FAIL range_idle: got w/d/r=%b want 000", {bus.vga_write, bus.done, bus.range_error});
    end
    $display("[TB] plot (160,0) rejected");
  endtask

  task automatic test_random_plots();
    int xs, ys;
    logic [15:0] col;
    logic in_rng;
    logic [17:0] want_pix;
    for (int i = 0; i < 30; i++) begin
      case (i)
        0: begin xs = 159; ys = 119; end
        1: begin xs = 160; ys = 0;   end
        2: begin xs = 0;   ys = 120; end
        3: begin xs = 0;   ys = 0;   end
        4: begin xs = 255; ys = 255; end
        5: begin xs = 159; ys = 120; end
        default: begin
          xs = int'($urandom_range(0, 199));
          ys = int'($urandom_range(0, 149));
        end
      endcase
      col = 16'($urandom);
      // Reference: on-screen iff both coordinates fall inside the visible area.
      in_rng = (xs < SW) && (ys < SH);
      want_pix = {8'(xs), 7'(ys), col[2:0]};
      bus.coord_value = {8'(xs), 8'(ys)};
      bus.color_value = col;
      bus.plot = 1'b1;
      tick();
      bus.plot = 1'b0;
      tick();
      tests_run++;
      if ({bus.vga_write, bus.done, bus.range_error, bus.busy} !== {in_rng, 1'b1, !in_rng, 1'b1}) begin
        tests_failed++;
        $display("FAIL rand_flags[%0d]: (%0d,%0d) got w/d/r/b=%b want %b", i, xs, ys,
                 {bus.vga_write, bus.done, bus.range_error, bus.busy},
                 {in_rng, 1'b1, !in_rng, 1'b1});
      end
      if (in_rng) begin
        tests_run++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== want_pix) begin
          tests_failed++;
          $display("FAIL rand_pixel[%0d]: got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d", i,
                   bus.vga_x, bus.vga_y, bus.vga_colour, xs, ys, col[2:0]);
        end
      end
      tick();
      tests_run++;
      if ({bus.vga_write, bus.done, bus.range_error, bus.busy} !== 4'd0) begin
        tests_failed++;
        $display("FAIL rand_idle[%0d]: got w/d/r/b=%b want 0000", i,
                 {bus.vga_write, bus.done, bus.range_error, bus.busy});
      end
      if (in_rng) begin
        tests_run++;
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== want_pix) begin
          tests_failed++;
          $display("FAIL rand_hold[%0d]: got (%0d,%0d) c=%0d want (%0d,%0d) c=%0d", i,
                   bus.vga_x, bus.vga_y, bus.vga_colour, xs, ys, col[2:0]);
        end
      end
      $display("[TB] plot (%0d,%0d) colour %0d in_range=%0b", xs, ys, col[2:0], in_rng);
    end
    tests_run++;
    if (bus.overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL rand_overrun: got %0b want 0", bus.overrun);
    end
  endtask

  task automatic test_back_to_back();
    bus.color_value = 16'h0003;
    bus.coord_value = {8'd20, 8'd30};
    bus.plot = 1'b1;
    tick();                                   // cycle 0: accepted
    bus.coord_value = {8'd40, 8'd50};         // cycle 1: must be dropped
    bus.color_value = 16'h0007;
    tick();
    tests_run++;
    if ({bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'd20, 7'd30, 3'd3}) begin
      tests_failed++;
      $display("FAIL b2b_first: got w=%0b (%0d,%0d) c=%0d want w=1 (20,30) c=3",
               bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    bus.coord_value = {8'd70, 8'd80};         // cycle 2: accepted
    bus.color_value = 16'h0001;
    tick();
    bus.plot = 1'b0;
    tests_run++;
    if (bus.vga_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_gap: got w=%0b want 0", bus.vga_write);
    end
    tick();
    tests_run++;
    if ({bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour} !== {1'b1, 8'd70, 7'd80, 3'd1}) begin
      tests_failed++;
      $display("FAIL b2b_second: got w=%0b (%0d,%0d) c=%0d want w=1 (70,80) c=1",
               bus.vga_write, bus.vga_x, bus.vga_y, bus.vga_colour);
    end
    tests_run++;
    if (bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_overrun: got %0b want 1", bus.overrun);
    end
    tick();
    $display("[TB] back-to-back plots (20,30),(70,80) with dropped (40,50)");
  endtask

  task automatic test_clear();
    int writes = 0;
    int order_err = 0;
    int dones = 0;
    int done_ok = 0;
    bus.clear_n = 1'b0;
    for (int c = 0; c < 40000; c++) begin
      tick();
      if (bus.vga_write === 1'b1) begin
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== {8'(writes % SW), 7'(writes / SW), 3'd0})
          order_err++;
        if (bus.done === 1'b1) begin
          dones++;
          if (writes == NPIX - 1) done_ok++;
        end
        writes++;
      end else if (bus.done === 1'b1) begin
        dones++;
      end
    end
    tests_run++;
    if (writes != NPIX) begin
      tests_failed++;
      $display("FAIL clear_count: got %0d writes want %0d", writes, NPIX);
    end
    tests_run++;
    if (order_err != 0) begin
      tests_failed++;
      $display("FAIL clear_order: got %0d misordered pixels want 0", order_err);
    end
    tests_run++;
    if (dones != 1 || done_ok != 1) begin
      tests_failed++;
      $display("FAIL clear_done: got %0d done pulses (%0d on last pixel) want 1 (1)", dones, done_ok);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_busy_end: got %0b want 0", bus.busy);
    end
    $display("[TB] clear held low 40000 cycles: %0d writes", writes);
  endtask

  task automatic test_reset_mid_clear();
    bus.clear_n = 1'b1;
    tick();
    bus.clear_n = 1'b0;
    tick();
    tests_run++;
    if ({bus.busy, bus.vga_write} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reclear_start: got b/w=%b want 10", {bus.busy, bus.vga_write});
    end
    tick();
    tests_run++;
    if ({bus.vga_write, bus.vga_x, bus.vga_y} !== {1'b1, 8'd0, 7'd0}) begin
      tests_failed++;
      $display("FAIL reclear_first: got w=%0b (%0d,%0d) want w=1 (0,0)",
               bus.vga_write, bus.vga_x, bus.vga_y);
    end
    repeat (100) tick();
    resetn = 1'b0;
    bus.clear_n = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_write, bus.busy, bus.done,
         bus.range_error, bus.overrun} !== 23'd0) begin
      tests_failed++;
      $display("FAIL midclear_reset: got x=%0d y=%0d w=%0b b=%0b o=%0b want all 0",
               bus.vga_x, bus.vga_y, bus.vga_write, bus.busy, bus.overrun);
    end
    resetn = 1'b1;
    tick();
    tests_run++;
    if ({bus.vga_write, bus.busy} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midclear_after: got w/b=%b want 00", {bus.vga_write, bus.busy});
    end
    tick();
    tests_run++;
    if (bus.vga_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL midclear_no_resume: got w=%0b want 0", bus.vga_write);
    end
    $display("[TB] reset mid-clear aborted sweep");
  endtask

  task automatic test_collision();
    int writes = 0;
    int order_err = 0;
    bus.coord_value = {8'd18, 8'd52};
    bus.color_value = 16'h0007;
    bus.plot = 1'b1;
    bus.clear_n = 1'b0;
    tick();
    bus.plot = 1'b0;
    tests_run++;
    if ({bus.overrun, bus.busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL collide_overrun: got o/b=%b want 11", {bus.overrun, bus.busy});
    end
    for (int c = 0; c < NPIX + 100; c++) begin
      bus.plot = (c == 5000);
      bus.coord_value = {8'd1, 8'd1};
      tick();
      if (bus.vga_write === 1'b1) begin
        if ({bus.vga_x, bus.vga_y, bus.vga_colour} !== {8'(writes % SW), 7'(writes / SW), 3'd0})
          order_err++;
        writes++;
      end
    end
    bus.plot = 1'b0;
    tests_run++;
    if (writes != NPIX) begin
      tests_failed++;
      $display("FAIL collide_count: got %0d writes want %0d", writes, NPIX);
    end
    tests_run++;
    if (order_err != 0) begin
      tests_failed++;
      $display("FAIL collide_order: got %0d misordered pixels want 0", order_err);
    end
    tests_run++;
    if (bus.overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL collide_sticky: got %0b want 1", bus.overrun);
    end
    bus.clear_n = 1'b1;
    tick();
    $display("[TB] clear with colliding plot: %0d writes", writes);
  endtask

  initial begin
    test_reset();
    test_plot();
    test_range();
    test_random_plots();
    test_back_to_back();
    test_clear();
    test_reset_mid_clear();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
